iterative_alu: RTL and testbench

- Parametrised, handshaked ALU for the next-generation MIPS150 datapath.
- Executes single-cycle ops in one registered cycle.
- Executes MULT/MULTU and DIV/DIVU iteratively (one bit per cycle), producing a HI/LO result pair.
- Sits in EX; the pipeline stalls on in_ready low or out_valid low.

---
 rtl/iterative_alu.sv | 178 +++++++++++++++++
 tb/tb_iterative_alu.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Handshaked MIPS150 execute-stage ALU: registered single-cycle ops plus
// bit-serial multiply (shift-add) and divide (restoring) producing a HI/LO pair.
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL,
    OP_SRA, OP_SRL, OP_LUI, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_RSVD
  } op_e;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_HOLD} state_e;

  state_e           r_state;
  state_e           w_next;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_b;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;

  op_e              w_op;
  logic             w_accept;
  logic             w_long;
  logic             w_is_div;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_q_bit;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_op     = op_e'(op);
  assign w_accept = in_valid & in_ready;
  assign w_long   = w_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign w_is_div = w_op inside {OP_DIV, OP_DIVU};
  assign w_signed = w_op inside {OP_MULT, OP_DIV};
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_sh     = b[SHW-1:0];

  // Iteration datapath: HI accumulates (multiply) or holds the partial remainder (divide).
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_rem_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_q_bit    = ~w_diff[WIDTH];
  assign w_prod_neg = -{r_hi, r_lo};

  assign out_lo = r_lo;
  assign out_hi = r_hi;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_XOR:  w_alu = a ^ b;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  w_alu = a << w_sh;
      OP_SRA:  w_alu = $signed(a) >>> w_sh;
      OP_SRL:  w_alu = a >> w_sh;
      OP_LUI:  w_alu = b << (WIDTH / 2);
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE, S_HOLD: begin
        in_ready  = (r_state == S_IDLE) | out_ready;
        out_valid = (r_state == S_HOLD);
        if (in_valid & in_ready) begin
          if (w_long) w_next = w_is_div ? S_DIV : S_MUL;
          else        w_next = S_HOLD;
        end else if (r_state == S_HOLD && out_ready) begin
          w_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (r_cnt == '0) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_HOLD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            r_hi <= '0;
            if (w_long) begin
              r_lo     <= w_a_mag;
              r_b      <= w_b_mag;
              r_cnt    <= CNT_LAST;
              r_is_div <= w_is_div;
              // A zero divisor keeps the quotient positive so it stays all ones.
              r_neg_q  <= (w_a_neg ^ w_b_neg) & (|b);
              r_neg_r  <= w_a_neg;
            end else begin
              r_lo <= w_alu;
            end
          end
        end
        S_MUL: begin
          r_hi <= w_mul_sum[WIDTH:1];
          r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          if (r_cnt != '0) r_cnt <= r_cnt - SHW'(1);
        end
        S_DIV: begin
          r_hi <= w_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], w_q_bit};
          if (r_cnt != '0) r_cnt <= r_cnt - SHW'(1);
        end
        S_FIX: begin
          if (r_is_div) begin
            r_lo <= r_neg_q ? -r_lo : r_lo;
            r_hi <= r_neg_r ? -r_hi : r_hi;
          end else if (r_neg_q) begin
            {r_hi, r_lo} <= w_prod_neg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: behavioural result/latency model checked every cycle,
// directed cases with literal expectations, random traffic, and a WIDTH=8 build.
module tb_iterative_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] out_lo;
  logic [W-1:0] out_hi;

  logic       v8 = 1'b0;
  logic       or8 = 1'b1;
  logic [3:0] op8 = '0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       rdy8;
  logic       ov8;
  logic       busy8;
  logic [7:0] lo8;
  logic [7:0] hi8;

  int checks = 0;
  int failures = 0;

  iterative_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_lo(out_lo), .out_hi(out_hi), .busy(busy)
  );

  iterative_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
    .op(op8), .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
    .out_lo(lo8), .out_hi(hi8), .busy(busy8)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {hi, lo} from the instruction-set rules in plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
    int sx;
    int sy;
    logic [63:0] r;
    sx = $signed(x);
    sy = $signed(y);
    r = '0;
    case (f)
      4'd0:  r = {32'h0, x + y};
      4'd1:  r = {32'h0, x - y};
      4'd2:  r = {32'h0, x & y};
      4'd3:  r = {32'h0, x | y};
      4'd4:  r = {32'h0, x ^ y};
      4'd5:  r = (sx < sy) ? 64'd1 : 64'd0;
      4'd6:  r = (x < y) ? 64'd1 : 64'd0;
      4'd7:  r = {32'h0, x << y[4:0]};
      4'd8:  r = {32'h0, $signed(x) >>> y[4:0]};
      4'd9:  r = {32'h0, x >> y[4:0]};
      4'd10: r = {32'h0, y << 16};
      4'd11: r = 64'(longint'(sx) * longint'(sy));
      4'd12: r = 64'(x) * 64'(y);
      4'd13: begin
        if (y == 32'h0)                                    r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, x};
        else                                               r = {sx % sy, sx / sy};
      end
      4'd14: begin
        if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
        else            r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Model: a held result, and a countdown for an in-flight long op.
  logic        m_valid = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_hi = '0;
  logic [63:0] m_pend = '0;

  always @(negedge clk) begin
    logic exp_busy;
    logic exp_rdy;
    if (!rst_n) begin
      check("reset_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_result", {out_hi, out_lo}, 0);
      m_valid = 1'b0;
      m_wait  = 0;
      m_lo    = '0;
      m_hi    = '0;
    end else begin
      exp_busy = (m_wait != 0);
      exp_rdy  = !exp_busy && (!m_valid || out_ready);
      check("model_valid", out_valid, m_valid);
      check("model_busy", busy, exp_busy);
      check("model_in_ready", in_ready, exp_rdy);
      if (!exp_busy) check("model_result", {out_hi, out_lo}, {m_hi, m_lo});
      if (m_wait != 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid      = 1'b1;
          {m_hi, m_lo} = m_pend;
        end
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (in_valid && exp_rdy) begin
          if (op inside {4'd11, 4'd12, 4'd13, 4'd14}) begin
            m_wait = W + 1;
            m_pend = ref_result(op, a, b);
          end else begin
            m_valid      = 1'b1;
            {m_hi, m_lo} = ref_result(op, a, b);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input logic [3:0] f, input logic [31:0] x,
                       input logic [31:0] y);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    op = f;
    a = x;
    b = y;
    while (!acc && n < 100) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({name, "_accept"}, acc, 1);
  endtask

  task automatic wait_result(input string name, input logic [31:0] elo, input logic [31:0] ehi,
                             input int elat);
    int   lat;
    logic saw_rdy;
    lat = 1;
    saw_rdy = 1'b0;
    while (!out_valid && lat < 200) begin
      saw_rdy |= in_ready;
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, elat);
    check({name, "_in_ready_low"}, saw_rdy, 0);
    check({name, "_lo"}, out_lo, elo);
    check({name, "_hi"}, out_hi, ehi);
  endtask

  task automatic run8(input string name, input logic [3:0] f, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] elo, input logic [7:0] ehi,
                      input int elat);
    int lat;
    v8 = 1'b1;
    op8 = f;
    a8 = x;
    b8 = y;
    check({name, "_in_ready"}, rdy8, 1);
    tick();
    v8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 50) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, elat);
    check({name, "_lo"}, lo8, elo);
    check({name, "_hi"}, hi8, ehi);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("por_valid", out_valid, 0);
    check("por_in_ready", in_ready, 1);
    check("por_lo", out_lo, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a multiply, then a plain add.
    out_ready = 1'b0;
    issue("mult_rst", 4'd11, 32'd5, 32'd7);
    repeat (9) tick();
    check("mid_mult_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_now_valid", out_valid, 0);
    check("rst_now_busy", busy, 0);
    check("rst_now_in_ready", in_ready, 1);
    check("rst_now_out", {out_hi, out_lo}, 0);
    tick();
    rst_n = 1'b1;
    issue("add_after_rst", 4'd0, 32'd3, 32'd4);
    wait_result("add_after_rst", 32'd7, 32'd0, 1);

    // Back-to-back single-cycle ops.
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 4'd0; a = 32'hFFFF_FFFF; b = 32'd1;
    tick();
    check("b2b_add_valid", out_valid, 1);
    check("b2b_add_lo", out_lo, 32'h0);
    op = 4'd5; a = 32'hFFFF_FFFF; b = 32'd1;
    tick();
    check("b2b_slt_lo", out_lo, 32'h1);
    op = 4'd8; a = 32'h8000_0000; b = 32'd4;
    tick();
    check("b2b_sra_lo", out_lo, 32'hF800_0000);
    check("b2b_sra_hi", out_hi, 32'h0);
    in_valid = 1'b0;
    tick();

    issue("mult", 4'd11, 32'hFFFF_FFFE, 32'd3);
    wait_result("mult", 32'hFFFF_FFFA, 32'hFFFF_FFFF, 34);
    issue("multu", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    out_ready = 1'b0;
    wait_result("multu", 32'h0000_0001, 32'hFFFF_FFFE, 34);

    // Backpressure: held result, in_valid pulses ignored.
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op = 4'd0; a = $urandom(); b = $urandom();
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_lo", out_lo, 32'h0000_0001);
      check("bp_hi", out_hi, 32'hFFFF_FFFE);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 4'd1; a = 32'd5; b = 32'd9;
    tick();
    in_valid = 1'b0;
    check("bp_sub_valid", out_valid, 1);
    check("bp_sub_lo", out_lo, 32'hFFFF_FFFC);
    check("bp_sub_hi", out_hi, 32'h0);

    issue("div_neg", 4'd13, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_neg", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    issue("divu", 4'd14, 32'd100, 32'd7);
    wait_result("divu", 32'd14, 32'd2, 34);
    issue("div_zero", 4'd13, 32'd5, 32'd0);
    wait_result("div_zero", 32'hFFFF_FFFF, 32'd5, 34);
    issue("div_ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_ovf", 32'h8000_0000, 32'h0, 34);

    // Random traffic; the negedge model checks every cycle.
    for (int c = 0; c < 5000; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 4'($urandom_range(0, 15));
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    run8("w8_mult", 4'd11, 8'h80, 8'h80, 8'h00, 8'h40, 10);
    run8("w8_sll", 4'd7, 8'h01, 8'h0B, 8'h08, 8'h00, 1);
    run8("w8_div_ovf", 4'd13, 8'h80, 8'hFF, 8'h80, 8'h00, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
